// File: rtl/vga_timing_pipe.sv
// vga_timing_pipe
// Parametrised VGA timing generator with a colour output stage. A clock
// divider produces a one-clk pixel tick (px_ce). Horizontal and vertical
// counters advance on each tick. Raw sync and active-video flags are delayed
// by LAT ticks so they line up with colour from a pixel source of fixed
// latency. The colour is then truncated to OBITS per channel and blanked
// outside the active area.
//
// Ports
//   clk            system clock
//   clr            asynchronous active-low reset
//   Rp/Gp/Bp       source colour for the pixel issued LAT ticks earlier
//   px_ce          pixel-tick enable, one clk wide
//   x_px / y_px    raw horizontal / vertical counters (including blanking)
//   frame_start    first tick of a frame
//   line_start     first tick of each line
//   hsync / vsync  sync outputs, aligned with the colour outputs
//   red/green/blue_monitor  quantised colour outputs
module vga_timing_pipe #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   PX_DIV   = 1,
  parameter int   LAT      = 2,
  parameter int   CBITS    = 8,
  parameter int   OBITS    = 1,
  parameter int   XW       = 10,
  parameter int   YW       = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [CBITS-1:0] Rp,
  input  logic [CBITS-1:0] Gp,
  input  logic [CBITS-1:0] Bp,
  output logic             px_ce,
  output logic [XW-1:0]    x_px,
  output logic [YW-1:0]    y_px,
  output logic             frame_start,
  output logic             line_start,
  output logic             hsync,
  output logic             vsync,
  output logic [OBITS-1:0] red_monitor,
  output logic [OBITS-1:0] green_monitor,
  output logic [OBITS-1:0] blue_monitor
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
  localparam logic [3:0]    DIV_LAST = 4'(PX_DIV - 1);

  logic [3:0]    div_q, div_d;
  logic          px_ce_q, px_ce_d;
  logic [XW-1:0] h_q, h_d;
  logic [YW-1:0] v_q, v_d;

  logic act_raw, hs_raw, vs_raw;
  logic act_dly, hs_dly, vs_dly;

  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [OBITS-1:0] red_q, red_d;
  logic [OBITS-1:0] green_q, green_d;
  logic [OBITS-1:0] blue_q, blue_d;

  // Only the top OBITS of each channel reach the monitor.
  logic unused_colour_lsbs;
  assign unused_colour_lsbs = ^{Rp, Gp, Bp};

  // Divider and counters
  always_comb begin
    div_d   = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    px_ce_d = (div_q == DIV_LAST);
    h_d     = h_q;
    v_d     = v_q;
    if (px_ce_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + YW'(1);
      end else begin
        h_d = h_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      div_q   <= '0;
      px_ce_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      div_q   <= div_d;
      px_ce_q <= px_ce_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Raw flags for the pixel currently being issued
  always_comb begin
    act_raw = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_raw  = (32'(h_q) >= HS_START) && (32'(h_q) < HS_END);
    vs_raw  = (32'(v_q) >= VS_START) && (32'(v_q) < VS_END);
  end

  // Alignment pipeline: {act, hs, vs} per stage, newest in the low bits.
  // A reset stage reads as blanked, non-sync.
  if (LAT == 0) begin : g_nolat
    assign act_dly = act_raw;
    assign hs_dly  = hs_raw;
    assign vs_dly  = vs_raw;
  end else begin : g_lat
    logic [3*LAT-1:0] sr_q, sr_d;
    if (LAT == 1) begin : g_one
      always_comb sr_d = px_ce_q ? {act_raw, hs_raw, vs_raw} : sr_q;
    end else begin : g_many
      always_comb sr_d = px_ce_q ? {sr_q[3*LAT-4:0], act_raw, hs_raw, vs_raw} : sr_q;
    end
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) sr_q <= '0;
      else      sr_q <= sr_d;
    end
    assign {act_dly, hs_dly, vs_dly} = sr_q[3*LAT-1 -: 3];
  end

  // Output register, loaded once per pixel tick
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (px_ce_q) begin
      hsync_d = hs_dly ? HS_POL : ~HS_POL;
      vsync_d = vs_dly ? VS_POL : ~VS_POL;
      red_d   = act_dly ? Rp[CBITS-1 -: OBITS] : '0;
      green_d = act_dly ? Gp[CBITS-1 -: OBITS] : '0;
      blue_d  = act_dly ? Bp[CBITS-1 -: OBITS] : '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign px_ce         = px_ce_q;
  assign x_px          = h_q;
  assign y_px          = v_q;
  assign line_start    = px_ce_q && (h_q == '0);
  assign frame_start   = px_ce_q && (h_q == '0) && (v_q == '0);
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign red_monitor   = red_q;
  assign green_monitor = green_q;
  assign blue_monitor  = blue_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe. Two instances share clock, reset and colour
// sources: "a" (PX_DIV=2, LAT=2, active-low syncs) and "b" (PX_DIV=1,
// LAT=0, active-high syncs). Both use an 8/2/3/2 x 4/1/2/1 geometry with
// 2-bit colour outputs. Expected values come from tick arithmetic.
module tb_vga_timing_pipe;

  localparam int HA = 8, HFP = 2, HSY = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 2, VBP = 1;
  localparam int HT = HA + HFP + HSY + HBP;
  localparam int VT = VA + VFP + VSY + VBP;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] Rp, Gp, Bp;

  logic       pce_a, fs_a, ls_a, hs_a, vs_a;
  logic [3:0] x_a;
  logic [2:0] y_a;
  logic [1:0] r_a, g_a, b_a;
  logic       pce_b, fs_b, ls_b, hs_b, vs_b;
  logic [3:0] x_b;
  logic [2:0] y_b;
  logic [1:0] r_b, g_b, b_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PX_DIV(2), .LAT(2),
    .CBITS(8), .OBITS(2), .XW(4), .YW(3)
  ) dut_a (
    .clk(clk), .clr(clr), .Rp(Rp), .Gp(Gp), .Bp(Bp),
    .px_ce(pce_a), .x_px(x_a), .y_px(y_a),
    .frame_start(fs_a), .line_start(ls_a),
    .hsync(hs_a), .vsync(vs_a),
    .red_monitor(r_a), .green_monitor(g_a), .blue_monitor(b_a)
  );

  vga_timing_pipe #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .PX_DIV(1), .LAT(0),
    .CBITS(8), .OBITS(2), .XW(4), .YW(3)
  ) dut_b (
    .clk(clk), .clr(clr), .Rp(Rp), .Gp(Gp), .Bp(Bp),
    .px_ce(pce_b), .x_px(x_b), .y_px(y_b),
    .frame_start(fs_b), .line_start(ls_b),
    .hsync(hs_b), .vsync(vs_b),
    .red_monitor(r_b), .green_monitor(g_b), .blue_monitor(b_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Tick k is the clk cycle after edge PX_DIV*(k+1) following reset release.
  function automatic bit pce_exp(input int c, input int d);
    return (c >= d) && (c % d == 0);
  endfunction

  // c: clk edges since release; l: pixel ticks completed so far.
  int c_a = 0, l_a = 0, c_b = 0, l_b = 0;
  logic [7:0] rh_a [1024], gh_a [1024], bh_a [1024];
  logic [7:0] rh_b [1024], gh_b [1024], bh_b [1024];

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      c_a <= 0; l_a <= 0; c_b <= 0; l_b <= 0;
    end else begin
      c_a <= c_a + 1;
      c_b <= c_b + 1;
      if (pce_exp(c_a, 2)) l_a <= l_a + 1;
      if (pce_exp(c_b, 1)) l_b <= l_b + 1;
    end
  end

  // Pixel issued on tick p sits at (p mod HT, (p / HT) mod VT). The output
  // loaded at the end of tick l-1 belongs to pixel l-1-lat and uses the
  // colour presented during tick l-1.
  task automatic check_inst(input string nm, input int c, input int l,
                            input int pxdiv, input int lat,
                            input logic hpol, input logic vpol,
                            input logic pce, input logic [31:0] x, input logic [31:0] y,
                            input logic fs, input logic ls,
                            input logic hsy, input logic vsy,
                            input logic [31:0] r, input logic [31:0] g, input logic [31:0] b,
                            input logic [7:0] rh, input logic [7:0] gh, input logic [7:0] bh);
    bit   pe;
    int   h, v, p, ph, pv;
    logic ehs, evs;
    int   er, eg, eb;
    pe  = pce_exp(c, pxdiv);
    h   = l % HT;
    v   = (l / HT) % VT;
    ehs = ~hpol;
    evs = ~vpol;
    er  = 0; eg = 0; eb = 0;
    p   = l - 1 - lat;
    if (p >= 0) begin
      ph = p % HT;
      pv = (p / HT) % VT;
      if (ph >= HA + HFP && ph < HA + HFP + HSY) ehs = hpol;
      if (pv >= VA + VFP && pv < VA + VFP + VSY) evs = vpol;
      if (ph < HA && pv < VA) begin
        er = int'(rh >> 6); eg = int'(gh >> 6); eb = int'(bh >> 6);
      end
    end
    chk({nm, ".px_ce"}, 32'(pce), 32'(pe));
    chk({nm, ".x_px"}, x, h);
    chk({nm, ".y_px"}, y, v);
    chk({nm, ".line_start"}, 32'(ls), 32'(pe && h == 0));
    chk({nm, ".frame_start"}, 32'(fs), 32'(pe && h == 0 && v == 0));
    chk({nm, ".hsync"}, 32'(hsy), 32'(ehs));
    chk({nm, ".vsync"}, 32'(vsy), 32'(evs));
    chk({nm, ".red"}, r, er);
    chk({nm, ".green"}, g, eg);
    chk({nm, ".blue"}, b, eb);
  endtask

  always @(negedge clk) begin
    check_inst("a", c_a, l_a, 2, 2, 1'b0, 1'b0, pce_a, 32'(x_a), 32'(y_a), fs_a, ls_a,
               hs_a, vs_a, 32'(r_a), 32'(g_a), 32'(b_a),
               rh_a[(l_a - 1) & 1023], gh_a[(l_a - 1) & 1023], bh_a[(l_a - 1) & 1023]);
    check_inst("b", c_b, l_b, 1, 0, 1'b1, 1'b1, pce_b, 32'(x_b), 32'(y_b), fs_b, ls_b,
               hs_b, vs_b, 32'(r_b), 32'(g_b), 32'(b_b),
               rh_b[(l_b - 1) & 1023], gh_b[(l_b - 1) & 1023], bh_b[(l_b - 1) & 1023]);
    if (clr && pce_exp(c_a, 2)) begin
      rh_a[l_a & 1023] <= Rp; gh_a[l_a & 1023] <= Gp; bh_a[l_a & 1023] <= Bp;
    end
    if (clr && pce_exp(c_b, 1)) begin
      rh_b[l_b & 1023] <= Rp; gh_b[l_b & 1023] <= Gp; bh_b[l_b & 1023] <= Bp;
    end
  end

  // Colour sources change just after each rising edge.
  initial begin
    Rp = 8'd0; Gp = 8'd0; Bp = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      Rp = 8'($urandom);
      Gp = 8'($urandom);
      Bp = 8'($urandom);
    end
  end

  initial begin
    bit found;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #2 clr = 1'b1;
    // Just over two frames of instance a (240 clk per frame)
    repeat (520) @(posedge clk);

    found = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      if (l_a % HT == 5 && (l_a / HT) % VT == 2) begin
        found = 1'b1;
        break;
      end
    end
    chk("reach_h5_v2", 32'(found), 32'd1);

    // Drop reset between edges and look before the next edge.
    #1 clr = 1'b0;
    #1;
    chk("arst.a.px_ce", 32'(pce_a), 32'd0);
    chk("arst.a.x_px", 32'(x_a), 32'd0);
    chk("arst.a.y_px", 32'(y_a), 32'd0);
    chk("arst.a.frame_start", 32'(fs_a), 32'd0);
    chk("arst.a.line_start", 32'(ls_a), 32'd0);
    chk("arst.a.hsync", 32'(hs_a), 32'd1);
    chk("arst.a.vsync", 32'(vs_a), 32'd1);
    chk("arst.a.colour", 32'({r_a, g_a, b_a}), 32'd0);
    chk("arst.b.px_ce", 32'(pce_b), 32'd0);
    chk("arst.b.hsync", 32'(hs_b), 32'd0);
    chk("arst.b.vsync", 32'(vs_b), 32'd0);
    chk("arst.b.colour", 32'({r_b, g_b, b_b}), 32'd0);

    repeat (3) @(posedge clk);
    #2 clr = 1'b1;
    repeat (600) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
# vga_timing_pipe

Parametrised VGA timing generator and colour output stage for the computer-vision display path. It generates horizontal and vertical pixel counters and sync pulses from configurable timing values, and takes per-channel colour from a pixel source with a known, fixed latency. It delays sync and blanking so they stay aligned with that colour, then drives quantised multi-bit colour to the monitor. It replaces the fixed 640x480, 1-bit-per-channel controller and sits between the clock source and the graphics generators.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch in lines
- HS_POL / VS_POL, 0 / 0, active level of hsync / vsync
- PX_DIV, 1, clk cycles per pixel tick (1..16)
- LAT, 2, pixel-source latency in pixel ticks (0..15)
- CBITS, 8, input colour width per channel
- OBITS, 1, monitor colour width per channel (1..CBITS)
- XW / YW, 10 / 10, counter widths; H_TOTAL ≤ 2^XW and V_TOTAL ≤ 2^YW
- clk  in  1  system clock
- clr  in  1  reset; asynchronous assert, active-low
- Rp / Gp / Bp  in  CBITS  colour for the pixel issued LAT ticks earlier
- px_ce  out  1  pixel-tick enable, one clk wide
- x_px  out  XW  horizontal counter (raw, including blanking)
- y_px  out  YW  vertical counter (raw, including blanking)
- frame_start  out  1  first tick of frame
- line_start  out  1  first tick of each line
- hsync / vsync  out  1  aligned sync outputs
- red_monitor / green_monitor / blue_monitor  out  OBITS  aligned colour outputs

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way.
- Divider: div counts 0..PX_DIV-1 and wraps. The px_ce register loads (div==PX_DIV-1). For PX_DIV=1, px_ce is high on every cycle after reset.
- Counters advance only on edges where px_ce=1.
  - h wraps from H_TOTAL-1 to 0.
  - v increments when h wraps, and wraps from V_TOTAL-1 to 0.
- x_px = h and y_px = v, both driven directly from the counter registers.
- Undelayed raw signals, computed from the counters:
  - act = h<H_ACTIVE && v<V_ACTIVE
  - hs = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC
  - vs is the same test on v with the V parameters
- line_start = px_ce && h==0. frame_start = line_start && v==0.
- Alignment pipeline: act, hs and vs enter a LAT-stage shift register that advances only on px_ce.
- Output register, loaded on px_ce:
  - hsync = delayed hs ? HS_POL : !HS_POL. vsync is formed the same way.
  - Each colour output = delayed act ? input[CBITS-1 -: OBITS] : 0. Truncation only, no rounding.
- For LAT=0 the shift register is absent and the output register samples the raw signals directly.

## Timing
- Reset (clr=0), effective immediately and asynchronously:
  - div, h, v and px_ce are 0.
  - All shift stages are inactive and deasserted.
  - hsync = !HS_POL, vsync = !VS_POL, all colour outputs 0.
  - frame_start and line_start are 0.
- Reset released mid-frame: restart at (0,0). No partial-frame state survives.
- After clr releases, the first px_ce occurs at clk edge PX_DIV. That tick carries h=v=0 and frame_start=1.
- Latency: the pixel whose counter value is presented on tick n has its colour sampled from Rp/Gp/Bp at the end of tick n+LAT. Its hsync, vsync and colour are visible during tick n+LAT+1.
- Outputs change only on px_ce edges. They hold for PX_DIV clk cycles.
- Simultaneous wraps: at h=H_TOTAL-1 and v=V_TOTAL-1, both counters go to 0 on the same edge.
- Blanking always forces colour to 0, regardless of input values.

## Test plan
- Setup: H=8/2/3/2, V=4/1/2/1, PX_DIV=2, LAT=2, CBITS=8, OBITS=2.
- Reset then release: px_ce first high at edge 2. frame_start is pulsed once, with x_px=0 and y_px=0. hsync=1 and vsync=1 until tick 13 (h=10 issued at tick 10 +LAT+1).
- Counter wrap: the h sequence 0..14 repeats every 15 ticks. v increments at each h wrap. After v=7,h=14, the next tick gives (0,0) and frame_start=1. The frame period is 120 ticks, i.e. 240 clk.
- Latency: a source returns Rp = x_px issued LAT ticks earlier. red_monitor equals the top 2 bits of x at tick x+3 for x = 0..7, and 0 during h blanking and v≥4.
- Sync polarity: with HS_POL=1 and VS_POL=1, hsync is high for exactly 3 ticks per line and vsync is high for 2 lines per frame. Idle level is 0 after reset.
- Async reset mid-frame: drop clr at (h=5,v=2) between clock edges. All outputs take their reset values without a clk edge. After release, the sequence restarts with frame_start.
- LAT=0, PX_DIV=1: px_ce is high on every cycle, and colour follows the input after one cycle.
